// File: rtl/dmem_arbiter.sv
// Data SRAM port arbiter: core load/store path vs. DMA requester.
// Core wins by default; a starvation counter forces single DMA slots.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 16,
  parameter int FAIR         = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_req,
  input  logic            core_we,
  input  logic [DW/8-1:0] core_ben,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  output logic [DW-1:0]   core_rdata,
  output logic            core_wait,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [DW/8-1:0] dma_ben,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_wdata,
  output logic            dma_gnt,
  output logic            dma_rvalid,
  output logic [DW-1:0]   dma_rdata,
  output logic            dma_starved,
  output logic            sram_cen,
  output logic            sram_wen,
  output logic [DW/8-1:0] sram_ben,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_din,
  input  logic [DW-1:0]   sram_dout
);

  typedef enum logic [1:0] {
    CORE_PRI  = 2'd0,
    FORCE_DMA = 2'd1
  } state_t;

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] starve_cnt;
  logic [7:0] cnt_nxt;
  logic       rd_valid;
  logic       rd_dma;
  logic       core_gnt;

  always_comb begin
    state_nxt = CORE_PRI;
    core_gnt  = 1'b0;
    dma_gnt   = 1'b0;
    core_wait = 1'b0;
    cnt_nxt   = starve_cnt;
    // reset overrides any request in the same cycle
    if (!rst) begin
      unique case (state)
        FORCE_DMA: begin
          dma_gnt   = dma_req;
          core_wait = core_req && (FAIR != 0);
        end
        default: begin
          core_gnt = core_req;
          dma_gnt  = dma_req && !core_req;
        end
      endcase
    end
    if (!dma_req || dma_gnt) begin
      cnt_nxt = 8'd0;
    end else if (starve_cnt != LIM) begin
      cnt_nxt = starve_cnt + 8'd1;
    end
    // enter the forced slot together with the counter reaching the limit
    if ((FAIR != 0) && (state == CORE_PRI) && dma_req &&
        !dma_gnt && (cnt_nxt == LIM)) begin
      state_nxt = FORCE_DMA;
    end
  end

  always_comb begin
    sram_cen  = !(core_gnt || dma_gnt);
    sram_wen  = 1'b1;
    sram_ben  = '1;
    sram_addr = core_addr;
    sram_din  = core_wdata;
    unique case (1'b1)
      dma_gnt: begin
        sram_wen  = !dma_we;
        sram_ben  = dma_ben;
        sram_addr = dma_addr;
        sram_din  = dma_wdata;
      end
      core_gnt: begin
        sram_wen  = !core_we;
        sram_ben  = core_ben;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CORE_PRI;
      starve_cnt <= 8'd0;
      rd_valid   <= 1'b0;
      rd_dma     <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      rd_valid   <= (core_gnt && !core_we) || (dma_gnt && !dma_we);
      rd_dma     <= dma_gnt && !dma_we;
    end
  end

  assign dma_rvalid  = rd_valid && rd_dma && !rst;
  assign dma_rdata   = sram_dout;
  assign core_rdata  = sram_dout;
  assign dma_starved = (starve_cnt == LIM);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (fair/16, strict/16, fair/1)
// checked each cycle against a rule-level model, plus directed pins.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sram_dout = '0;
  bit          run = 1'b0;

  logic        core_req [3];
  logic        core_we [3];
  logic [3:0]  core_ben [3];
  logic [31:0] core_addr [3];
  logic [31:0] core_wdata [3];
  logic [31:0] core_rdata [3];
  logic        core_wait [3];
  logic        dma_req [3];
  logic        dma_we [3];
  logic [3:0]  dma_ben [3];
  logic [31:0] dma_addr [3];
  logic [31:0] dma_wdata [3];
  logic        dma_gnt [3];
  logic        dma_rvalid [3];
  logic [31:0] dma_rdata [3];
  logic        dma_starved [3];
  logic        sram_cen [3];
  logic        sram_wen [3];
  logic [3:0]  sram_ben [3];
  logic [31:0] sram_addr [3];
  logic [31:0] sram_din [3];

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt [3];
  bit m_force [3];
  bit m_ov [3];
  bit m_od [3];
  bit m_gnt_last [3];
  bit m_wait_last [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter #(
      .AW(32), .DW(32),
      .STARVE_LIMIT(g == 2 ? 1 : 16),
      .FAIR(g == 1 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req[g]), .core_we(core_we[g]),
      .core_ben(core_ben[g]), .core_addr(core_addr[g]),
      .core_wdata(core_wdata[g]), .core_rdata(core_rdata[g]),
      .core_wait(core_wait[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]),
      .dma_ben(dma_ben[g]), .dma_addr(dma_addr[g]),
      .dma_wdata(dma_wdata[g]), .dma_gnt(dma_gnt[g]),
      .dma_rvalid(dma_rvalid[g]), .dma_rdata(dma_rdata[g]),
      .dma_starved(dma_starved[g]),
      .sram_cen(sram_cen[g]), .sram_wen(sram_wen[g]),
      .sram_ben(sram_ben[g]), .sram_addr(sram_addr[g]),
      .sram_din(sram_din[g]), .sram_dout(sram_dout)
    );

    a_dma_hold: assert property (@(posedge clk) disable iff (rst)
      (dma_req[g] && !dma_gnt[g]) |=>
        (dma_req[g] && $stable(dma_we[g]) && $stable(dma_ben[g]) &&
         $stable(dma_addr[g]) && $stable(dma_wdata[g])))
      else $error("FAIL dma_hold[%0d] request changed before grant", g);
  end

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got %h want %h", nm, i, $time, act, exp);
    end
  endtask

  // Model: outputs follow from the priority rules, the waiting count
  // and whether the previous cycle earned a forced DMA slot.
  always @(negedge clk) begin : model
    bit          cg, dg, cw, e_rv, e_wen;
    logic [3:0]  e_ben;
    logic [31:0] e_addr, e_din;
    int          lim, ncnt;
    bit          fair;
    if (run) begin
      for (int i = 0; i < 3; i++) begin
        fair = (i != 1);
        lim  = (i == 2) ? 1 : 16;
        cg = 0; dg = 0; cw = 0;
        if (!rst) begin
          if (m_force[i]) begin
            dg = dma_req[i];
            cw = core_req[i];
          end else begin
            cg = core_req[i];
            dg = dma_req[i] && !core_req[i];
          end
        end
        e_wen  = dg ? !dma_we[i] : (cg ? !core_we[i] : 1'b1);
        e_ben  = dg ? dma_ben[i] : (cg ? core_ben[i] : 4'hF);
        e_addr = dg ? dma_addr[i] : core_addr[i];
        e_din  = dg ? dma_wdata[i] : core_wdata[i];
        e_rv   = !rst && m_ov[i] && m_od[i];
        chk("dma_gnt", i, dma_gnt[i], dg);
        chk("core_wait", i, core_wait[i], cw);
        chk("sram_cen", i, sram_cen[i], !(cg || dg));
        chk("sram_wen", i, sram_wen[i], e_wen);
        chk("sram_ben", i, sram_ben[i], e_ben);
        chk("sram_addr", i, sram_addr[i], e_addr);
        chk("sram_din", i, sram_din[i], e_din);
        chk("dma_rvalid", i, dma_rvalid[i], e_rv);
        chk("dma_starved", i, dma_starved[i], m_cnt[i] == lim);
        chk("core_rdata", i, core_rdata[i], sram_dout);
        if (e_rv) chk("dma_rdata", i, dma_rdata[i], sram_dout);
        m_gnt_last[i]  = dg;
        m_wait_last[i] = cw;
        if (rst) begin
          m_cnt[i] = 0; m_force[i] = 0; m_ov[i] = 0; m_od[i] = 0;
        end else begin
          m_ov[i] = (cg && !core_we[i]) || (dg && !dma_we[i]);
          m_od[i] = dg && !dma_we[i];
          if (!dma_req[i] || dg) ncnt = 0;
          else ncnt = (m_cnt[i] + 1 > lim) ? lim : m_cnt[i] + 1;
          m_force[i] = fair && !m_force[i] && dma_req[i] && !dg &&
                       ncnt == lim;
          m_cnt[i] = ncnt;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(bit r, bit we, logic [3:0] ben,
                          logic [31:0] a, logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      core_req[i] = r; core_we[i] = we; core_ben[i] = ben;
      core_addr[i] = a; core_wdata[i] = d;
    end
  endtask

  task automatic set_dma(bit r, bit we, logic [3:0] ben,
                         logic [31:0] a, logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      dma_req[i] = r; dma_we[i] = we; dma_ben[i] = ben;
      dma_addr[i] = a; dma_wdata[i] = d;
    end
  endtask

  task automatic rand_drive(int cdens, int ddens);
    for (int i = 0; i < 3; i++) begin
      if (!m_wait_last[i]) begin
        core_req[i]   = $urandom_range(0, 99) < cdens;
        core_we[i]    = 1'($urandom);
        core_ben[i]   = 4'($urandom);
        core_addr[i]  = $urandom & 32'hFFFF_FFFC;
        core_wdata[i] = $urandom;
      end
      if (!(dma_req[i] && !m_gnt_last[i])) begin
        dma_req[i]   = $urandom_range(0, 99) < ddens;
        dma_we[i]    = 1'($urandom);
        dma_ben[i]   = 4'($urandom);
        dma_addr[i]  = $urandom & 32'hFFFF_FFFC;
        dma_wdata[i] = $urandom;
      end
    end
    sram_dout = $urandom;
  endtask

  initial begin
    logic [31:0] v;
    int g1, w1;
    set_core(0, 0, 4'hF, 0, 0);
    set_dma(0, 0, 4'hF, 0, 0);
    tick();
    run = 1'b1;
    tick();
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_cen", 0, sram_cen[0], 1'b1);
      chk("idle_ben", 0, sram_ben[0], 4'b1111);
      chk("idle_rvalid", 0, dma_rvalid[0], 1'b0);
      chk("idle_starved", 0, dma_starved[0], 1'b0);
      tick();
    end

    set_dma(1, 0, 4'h0, 32'h40, 0);
    @(negedge clk);
    chk("rd_gnt", 0, dma_gnt[0], 1'b1);
    chk("rd_cen", 0, sram_cen[0], 1'b0);
    chk("rd_addr", 0, sram_addr[0], 32'h40);
    tick();
    set_dma(0, 0, 4'hF, 0, 0);
    sram_dout = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_rvalid", 0, dma_rvalid[0], 1'b1);
    chk("rd_rdata", 0, dma_rdata[0], 32'hDEADBEEF);
    chk("rd_cen_off", 0, sram_cen[0], 1'b1);
    tick();

    v = 0;
    for (int k = 0; k < 4; k++) begin
      set_core(1, 1, 4'b1100, 32'h10, 32'hA0 + k);
      set_dma(0, 0, 4'hF, 0, 0);
      sram_dout = v;
      @(negedge clk);
      chk("alt_wen", 0, sram_wen[0], 1'b0);
      chk("alt_ben", 0, sram_ben[0], 4'b1100);
      chk("alt_addr", 0, sram_addr[0], 32'h10);
      if (k > 0) begin
        chk("alt_rvalid", 0, dma_rvalid[0], 1'b1);
        chk("alt_rdata", 0, dma_rdata[0], v);
      end
      tick();
      set_core(0, 0, 4'hF, 0, 0);
      set_dma(1, 0, 4'h0, 32'h80 + 4 * k, 0);
      v = $urandom;
      sram_dout = v;
      @(negedge clk);
      chk("alt_wr_norv", 0, dma_rvalid[0], 1'b0);
      chk("alt_dgnt", 0, dma_gnt[0], 1'b1);
      tick();
      v = $urandom;
    end
    set_dma(0, 0, 4'hF, 0, 0);
    sram_dout = v;
    @(negedge clk);
    chk("alt_rdata_last", 0, dma_rdata[0], v);
    tick();

    g1 = 0;
    w1 = 0;
    set_core(1, 1, 4'h0, 32'h100, 32'h55);
    set_dma(1, 0, 4'h0, 32'h40, 0);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c <= 16) chk("stv_deny", 0, dma_gnt[0], 1'b0);
      if (c == 16) chk("stv_c16", 0, dma_starved[0], 1'b0);
      if (c == 17) begin
        chk("stv_fgnt", 0, dma_gnt[0], 1'b1);
        chk("stv_fwait", 0, core_wait[0], 1'b1);
        chk("stv_fstarved", 0, dma_starved[0], 1'b1);
        chk("stv_faddr", 0, sram_addr[0], 32'h40);
      end
      if (c == 18) begin
        chk("stv_c18gnt", 0, dma_gnt[0], 1'b0);
        chk("stv_c18wait", 0, core_wait[0], 1'b0);
        chk("stv_c18starved", 0, dma_starved[0], 1'b0);
        chk("stv_c18addr", 0, sram_addr[0], 32'h100);
      end
      g1 += int'(dma_gnt[1]);
      w1 += int'(core_wait[1]);
      tick();
    end
    set_core(0, 0, 4'hF, 0, 0);
    @(negedge clk);
    chk("strict_gnts", 1, g1, 0);
    chk("strict_waits", 1, w1, 0);
    chk("strict_starved", 1, dma_starved[1], 1'b1);
    chk("strict_drain", 1, dma_gnt[1], 1'b1);
    tick();
    set_dma(0, 0, 4'hF, 0, 0);
    tick();

    set_dma(1, 0, 4'h0, 32'h44, 0);
    @(negedge clk);
    chk("rst_pre_gnt", 0, dma_gnt[0], 1'b1);
    tick();
    rst = 1'b1;
    set_dma(0, 0, 4'hF, 0, 0);
    @(negedge clk);
    chk("rst_norv", 0, dma_rvalid[0], 1'b0);
    tick();
    @(negedge clk);
    chk("rst_cen", 0, sram_cen[0], 1'b1);
    chk("rst_wen", 0, sram_wen[0], 1'b1);
    chk("rst_ben", 0, sram_ben[0], 4'hF);
    chk("rst_starved", 0, dma_starved[0], 1'b0);
    tick();
    rst = 1'b0;
    set_dma(1, 0, 4'h0, 32'h48, 0);
    @(negedge clk);
    chk("rst_post_gnt", 0, dma_gnt[0], 1'b1);
    chk("rst_post_rv", 0, dma_rvalid[0], 1'b0);
    tick();
    set_dma(0, 0, 4'hF, 0, 0);
    @(negedge clk);
    chk("rst_post_rv2", 0, dma_rvalid[0], 1'b1);
    tick();

    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 300; k++) begin
        rand_drive(p == 0 ? 30 : (p == 1 ? 85 : 100), 60);
        tick();
      end
    end
    for (int k = 0; k < 4; k++) begin
      rand_drive(0, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous data SRAM port between the RV32E core's load/store path and a DMA requester (image line loader / result writer).
- Core has priority by default. DMA is served on idle core cycles.
- A starvation counter forces a one-cycle DMA slot and holds the core off with core_wait. The top level gates the core's inst_ready with core_wait.
- Routes the one-cycle-latency SRAM read data back to the requester that issued the read.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 bits.
- STARVE_LIMIT, 16, consecutive denied DMA cycles before a forced DMA slot; legal range 1..255.
- FAIR, 1, 1 = forced-slot mechanism enabled; 0 = strict core priority (flag only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- core_req  in  1  core access request, valid this cycle
- core_we  in  1  1 = write
- core_ben  in  DW/8  byte enables, active-low
- core_addr  in  AW  byte address
- core_wdata  in  DW  write data
- core_rdata  out  DW  read data, valid the cycle after a granted core read
- core_wait  out  1  core request not accepted this cycle; core holds request
- dma_req  in  1  DMA request; held with all fields stable until dma_gnt
- dma_we  in  1  1 = write
- dma_ben  in  DW/8  byte enables, active-low
- dma_addr  in  AW  byte address
- dma_wdata  in  DW  write data
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  dma_rdata valid (one cycle after a granted DMA read)
- dma_rdata  out  DW  read data
- dma_starved  out  1  starvation counter at STARVE_LIMIT
- sram_cen  out  1  chip enable, active-low
- sram_wen  out  1  write enable, active-low
- sram_ben  out  DW/8  byte enables, active-low
- sram_addr  out  AW  address
- sram_din  out  DW  write data
- sram_dout  in  DW  read data, one cycle after the address edge

Behaviour:
- Grant is combinational in the request cycle; the SRAM samples its signals at the next posedge.
- State machine (registered, 2 bits):
  - CORE_PRI: the core is granted whenever core_req=1. DMA is granted if dma_req=1 and core_req=0.
  - FORCE_DMA: entered from CORE_PRI when FAIR=1, starve_cnt==STARVE_LIMIT and dma_req=1. Lasts exactly one cycle. DMA is granted unconditionally. core_wait=core_req. Returns to CORE_PRI next cycle.
  - No back-to-back forced slots: the counter clears on the forced grant.
- Starvation counter (8-bit):
  - Increments on every cycle with dma_req=1 and dma_gnt=0.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on dma_gnt or when dma_req=0.
  - dma_starved = (starve_cnt==STARVE_LIMIT), registered value.
- SRAM drive:
  - The granted requester's we, ben, addr and wdata are muxed to the SRAM. sram_wen = !we.
  - With no grant: sram_cen=1, sram_wen=1, sram_ben=all 1s, addr and din hold the core's values.
- Read routing:
  - rd_owner register captures {valid, is_dma} for a granted read.
  - Next cycle: dma_rvalid = valid & is_dma, dma_rdata = sram_dout.
  - core_rdata = sram_dout at all times; the core tracks its own read timing.
- Writes produce no response.
- Simultaneous core_req and dma_req in CORE_PRI: core wins, dma_gnt=0, counter increments.
- A DMA request whose fields change before dma_gnt is a protocol violation; behaviour is unspecified (assertion in bench).
- Reset (rst=1 at posedge) takes priority over all inputs, including mid-request and mid-read. On reset:
  - state=CORE_PRI, starve_cnt=0, rd_owner=0.
  - Outputs the following cycle: dma_rvalid=0, dma_starved=0, sram_cen=1, sram_wen=1, sram_ben=all 1s, core_wait=0, dma_gnt=0 (unless inputs request).
  - A read outstanding at reset never returns dma_rvalid.
- core_wait=1 only in FORCE_DMA with core_req=1. With FAIR=0, core_wait is tied 0 and FORCE_DMA is unreachable.
- Latency: a granted read returns 1 cycle after grant. A DMA request waits at most STARVE_LIMIT+1 cycles under continuous core traffic (FAIR=1).

Test Plan:
- Only dma_req=1, we=0, addr=0x40; SRAM model returns 0xDEADBEEF -> dma_gnt=1 the same cycle, dma_rvalid=1 with rdata=0xDEADBEEF the next cycle, sram_cen=0 for one cycle.
- core_req and dma_req both held, STARVE_LIMIT=16 -> core granted 16 cycles, dma_starved=1, forced slot on cycle 17 with core_wait=1 and dma_gnt=1, core granted again on cycle 18, counter back to 0.
- FAIR=0, same stimulus for 100 cycles -> dma_gnt never 1, dma_starved stays 1, core_wait stays 0.
- Alternating core write (addr 0x10, ben 4'b1100) and DMA read on core-idle cycles -> SRAM sees the core write with ben=1100, DMA read data routed only to dma_rdata, dma_rvalid never set after the core write.
- rst asserted the cycle after a DMA read grant -> no dma_rvalid, all SRAM controls inactive, counter 0; normal arbitration resumes the cycle after rst deasserts.
- Idle (no requests) for 10 cycles -> sram_cen=1, sram_ben=4'b1111, dma_rvalid=0, counter 0.
